hex_word_streamer: RTL
======================

# hex_word_streamer

Serializes a captured binary word into a line of ASCII hex text for the smart-home status/debug UART path. Accepts one word (plus an optional ASCII tag character) over a valid/ready handshake. Walks the word MSB nibble first through the external nibble-to-ASCII hex converter and emits the framed characters one byte at a time over a second valid/ready handshake to the UART transmitter.

## Interface
- DATA_W, 16, word width in bits; multiple of 4, range 4..32; NIBBLES = DATA_W/4
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- word_valid  input  1  upstream word available
- word_ready  output  1  block can accept a word
- word_data  input  DATA_W  binary word to print
- word_tag  input  8  ASCII tag char sent before digits; 8'h00 = no tag
- nibble  output  4  nibble presented to hex converter
- hex_ascii  input  8  converter result for `nibble` (combinational, same cycle)
- tx_valid  output  1  tx_data holds a character
- tx_ready  input  1  UART transmitter accepts character
- tx_data  output  8  character to transmit
- busy  output  1  frame in progress
- frame_count  output  8  completed frames, wraps

## Operation
- Frame: [tag if word_tag != 0], NIBBLES hex digits MSB first, 8'h0D, 8'h0A.
- States: IDLE, TAG, DIGIT, CR, LF.
- IDLE: word_ready=1, tx_valid=0, tx_data=8'h00, nibble=4'h0. On word_valid: capture word_data to word_q and word_tag to tag_q; set idx=NIBBLES-1; go to TAG if word_tag != 0, else DIGIT.
- TAG: tx_data=tag_q. On tx transfer -> DIGIT.
- DIGIT: nibble=word_q[4*idx+3 : 4*idx]; tx_data=hex_ascii. On transfer: if idx==0 -> CR, else idx decrements.
- CR: tx_data=8'h0D. On transfer -> LF.
- LF: tx_data=8'h0A. On transfer -> IDLE and frame_count increments (255 -> 0).
- Transfer = tx_valid && tx_ready. tx_valid=1 in every non-IDLE state; busy = (state != IDLE).
- nibble=4'h0 outside DIGIT.
- word_ready=1 only in IDLE. word_valid/word_data/word_tag are ignored while busy; captured copies are used for the whole frame.
- tx_data and nibble depend only on registered state, so they are stable while tx_valid && !tx_ready. No character is skipped or duplicated.
- Reset (asserted at any time, including mid-frame): state=IDLE, word_q=0, tag_q=0, idx=0, frame_count=0. The aborted frame emits no further characters. Outputs: word_ready=1, tx_valid=0, tx_data=8'h00, nibble=4'h0, busy=0, frame_count=0.

## Timing
- Word accepted at clock edge E. First character valid in the cycle after E. No combinational path from word_valid to tx_*.
- With tx_ready held high: one character per cycle. Frame length is NIBBLES+2 characters, +1 if tagged.
- word_ready rises in the cycle after the LF transfer, so there is one idle cycle between frames. Tagged 16-bit frame with no backpressure: 8 cycles from accept to next accept.
- frame_count updates on the same edge as the LF transfer.
- No combinational path from tx_ready to tx_valid, tx_data or word_ready.

## Test plan
- Reset: hold rst_n=0 mid-traffic, then release -> word_ready=1, tx_valid=0, tx_data=8'h00, busy=0, frame_count=0 immediately and after release.
- DATA_W=16, word 0x1A3F, tag 8'h54, tx_ready=1 -> tx_data 54,31,41,33,46,0D,0A on 7 consecutive cycles starting the cycle after accept; word_ready=1 on the 8th cycle; frame_count=1.
- Tag 8'h00, word 0x0000 -> 30,30,30,30,0D,0A; no tag byte.
- Backpressure: word 0xBEEF untagged, tx_ready=0 for 5 cycles while second digit (45) is presented -> tx_data stays 45 and nibble stays 4'hE. Full sequence 42,45,45,46,0D,0A is delivered exactly once.
- Busy-time input: change word_data and hold word_valid=1 during a frame -> no capture, output matches the original word; the new word is accepted in the first IDLE cycle.
- Reset after 2 characters of a frame -> tx_valid=0 immediately, no further characters, frame_count=0. The next word produces a complete frame. Also run 256 frames and confirm frame_count wraps 255 -> 0.

Source files
------------

// File: rtl/hex_word_streamer.sv
// hex_word_streamer: prints a captured binary word as one line of ASCII hex text.
// Frame = [optional tag char], DATA_W/4 hex digits MSB first, CR, LF. The
// nibble-to-ASCII conversion lives outside this block: nibble_o goes out and
// hex_ascii_i comes back in the same cycle. All tx outputs are decoded from
// registered state only, so they hold steady under backpressure and there is no
// combinational path from word_valid_i or tx_ready_i to any output.
module hex_word_streamer #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              word_valid_i,
   output logic              word_ready_o,
   input  logic [DATA_W-1:0] word_data_i,
   input  logic [7:0]        word_tag_i,
   output logic [3:0]        nibble_o,
   input  logic [7:0]        hex_ascii_i,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic [7:0]        tx_data_o,
   output logic              busy_o,
   output logic [7:0]        frame_count_o
);

   localparam int unsigned Nibbles = DATA_W / 4;
   // Keep the index at least one bit wide so DATA_W=4 still elaborates.
   localparam int unsigned IdxW    = (Nibbles > 1) ? $clog2(Nibbles) : 1;
   localparam logic [IdxW-1:0] IdxTop = IdxW'(Nibbles - 1);

   localparam logic [7:0] AsciiCr = 8'h0D;
   localparam logic [7:0] AsciiLf = 8'h0A;

   typedef enum logic [2:0] {
      StIdle,
      StTag,
      StDigit,
      StCr,
      StLf
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic [7:0]          tag_q, tag_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [7:0]          frame_cnt_q, frame_cnt_d;

   logic                tx_fire;
   logic [IdxW+1:0]     nib_lsb;

   // A character leaves the block only on a completed valid/ready handshake.
   assign tx_fire = tx_valid_o & tx_ready_i;

   // Bit position of the nibble currently being printed.
   assign nib_lsb = {idx_q, 2'b00};

   assign busy_o        = (state_q != StIdle);
   assign frame_count_o = frame_cnt_q;

   // Output decode: purely a function of registered state (plus the converter's reply).
   always_comb begin
      word_ready_o = 1'b0;
      tx_valid_o   = 1'b1;
      tx_data_o    = 8'h00;
      nibble_o     = 4'h0;
      unique case (state_q)
         StIdle: begin
            word_ready_o = 1'b1;
            tx_valid_o   = 1'b0;
         end
         StTag: begin
            tx_data_o = tag_q;
         end
         StDigit: begin
            nibble_o  = word_q[nib_lsb +: 4];
            tx_data_o = hex_ascii_i;
         end
         StCr: begin
            tx_data_o = AsciiCr;
         end
         StLf: begin
            tx_data_o = AsciiLf;
         end
         default: begin
            tx_valid_o = 1'b0;
         end
      endcase
   end

   // Next-state: capture in idle, then step through the frame one transfer at a time.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      tag_d       = tag_q;
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (word_valid_i) begin
               word_d  = word_data_i;
               tag_d   = word_tag_i;
               idx_d   = IdxTop;
               state_d = (word_tag_i != 8'h00) ? StTag : StDigit;
            end
         end
         StTag: begin
            if (tx_fire) begin
               state_d = StDigit;
            end
         end
         StDigit: begin
            if (tx_fire) begin
               if (idx_q == '0) begin
                  state_d = StCr;
               end else begin
                  idx_d = idx_q - IdxW'(1);
               end
            end
         end
         StCr: begin
            if (tx_fire) begin
               state_d = StLf;
            end
         end
         StLf: begin
            if (tx_fire) begin
               state_d     = StIdle;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers; reset aborts any frame in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         word_q      <= '0;
         tag_q       <= 8'h00;
         idx_q       <= '0;
         frame_cnt_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         tag_q       <= tag_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule
